// File: rtl/l2_pkg.sv
// Shared L2 snoop types and address-split helpers.
package l2_pkg;

    typedef enum logic [1:0] {
        MesiI = 2'd0,
        MesiS = 2'd1,
        MesiE = 2'd2,
        MesiM = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        OpRead  = 2'd0,
        OpWrite = 2'd1,
        OpRwim  = 2'd2,
        OpInval = 2'd3
    } bus_op_e;

    // 2'b11 is never produced.
    typedef enum logic [1:0] {
        ResNohit = 2'd0,
        ResHit   = 2'd1,
        ResHitm  = 2'd2
    } snoop_res_e;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StLookup    = 2'd1,
        StRespond   = 2'd2,
        StWriteback = 2'd3
    } snoop_state_e;

    // Helpers work on a 64-bit carrier; callers size-cast the result to their field width.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned off_bits,
                                               input int unsigned idx_bits);
        return (addr >> off_bits) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned off_bits,
                                             input int unsigned idx_bits);
        return addr >> (off_bits + idx_bits);
    endfunction

    function automatic logic [63:0] addr_line_base(input logic [63:0] addr,
                                                   input int unsigned off_bits);
        return (addr >> off_bits) << off_bits;
    endfunction

endpackage

// File: rtl/mesi_snoop_next.sv
// Combinational snoop decision: bus op and current MESI state to result and new state.
module mesi_snoop_next
    import l2_pkg::*;
(
    input  bus_op_e    op_i,
    input  mesi_e      mesi_i,
    input  logic       hit_i,
    output snoop_res_e result_o,
    output mesi_e      next_mesi_o,
    output logic       do_update_o,
    output logic       do_writeback_o,
    output logic       error_o
);

    mesi_e cur_mesi;

    // A directory miss behaves exactly like an Invalid line.
    assign cur_mesi = hit_i ? mesi_i : MesiI;

    // Decode the MESI transition table for a remote bus operation.
    always_comb begin
        result_o       = ResNohit;
        next_mesi_o    = cur_mesi;
        do_update_o    = 1'b0;
        do_writeback_o = 1'b0;
        error_o        = 1'b0;
        unique case (op_i)
            OpRead: begin
                case (cur_mesi)
                    MesiM: begin
                        result_o       = ResHitm;
                        next_mesi_o    = MesiS;
                        do_update_o    = 1'b1;
                        do_writeback_o = 1'b1;
                    end
                    MesiE: begin
                        result_o    = ResHit;
                        next_mesi_o = MesiS;
                        do_update_o = 1'b1;
                    end
                    MesiS:   result_o = ResHit;
                    default: ;
                endcase
            end
            // Another cache writing back its own line never touches ours.
            OpWrite: ;
            OpRwim: begin
                case (cur_mesi)
                    MesiM: begin
                        result_o       = ResHitm;
                        next_mesi_o    = MesiI;
                        do_update_o    = 1'b1;
                        do_writeback_o = 1'b1;
                    end
                    MesiE, MesiS: begin
                        result_o    = ResHit;
                        next_mesi_o = MesiI;
                        do_update_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            OpInval: begin
                case (cur_mesi)
                    MesiS: begin
                        result_o    = ResHit;
                        next_mesi_o = MesiI;
                        do_update_o = 1'b1;
                    end
                    // Nobody may invalidate a line we own exclusively.
                    MesiE, MesiM: error_o = 1'b1;
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/snoop_responder.sv
// Snoop bus responder: directory lookup, MESI update and writeback sequencing.
module snoop_responder
    import l2_pkg::*;
#(
    parameter int unsigned ways       = 8,
    parameter int unsigned indexBits  = 14,
    parameter int unsigned tagBits    = 12,
    parameter int unsigned offsetBits = 6,
    localparam int unsigned AW        = tagBits + indexBits + offsetBits,
    localparam int unsigned WayW      = $clog2(ways)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 snoop_valid,
    input  logic [1:0]           snoop_op,
    input  logic [AW-1:0]        snoop_addr,
    output logic                 snoop_ready,
    output logic                 lookup_req,
    output logic [indexBits-1:0] lookup_index,
    output logic [tagBits-1:0]   lookup_tag,
    input  logic                 lookup_ack,
    input  logic                 lookup_hit,
    input  logic [WayW-1:0]      lookup_way,
    input  logic [1:0]           lookup_mesi,
    output logic                 upd_valid,
    output logic [indexBits-1:0] upd_index,
    output logic [WayW-1:0]      upd_way,
    output logic [1:0]           upd_mesi,
    output logic                 result_valid,
    output logic [1:0]           snoop_result,
    output logic                 wb_req,
    output logic [AW-1:0]        wb_addr,
    input  logic                 wb_ack,
    output logic                 protocol_error
);

    snoop_state_e         state_q;
    bus_op_e              op_q;
    logic [AW-1:0]        addr_q;
    logic                 snoop_ready_q;
    logic                 lookup_req_q;
    logic [indexBits-1:0] lookup_index_q;
    logic [tagBits-1:0]   lookup_tag_q;
    logic                 result_valid_q;
    snoop_res_e           snoop_result_q;
    logic                 upd_valid_q;
    logic [indexBits-1:0] upd_index_q;
    logic [WayW-1:0]      upd_way_q;
    mesi_e                upd_mesi_q;
    logic                 wb_pending_q;
    logic                 wb_req_q;
    logic [AW-1:0]        wb_addr_q;
    logic                 protocol_error_q;

    snoop_res_e nx_result;
    mesi_e      nx_mesi;
    logic       nx_update;
    logic       nx_writeback;
    logic       nx_error;

    // Fed from the live directory response so RESPOND outputs can be registered on the ack edge.
    mesi_snoop_next u_next (
        .op_i           (op_q),
        .mesi_i         (mesi_e'(lookup_mesi)),
        .hit_i          (lookup_hit),
        .result_o       (nx_result),
        .next_mesi_o    (nx_mesi),
        .do_update_o    (nx_update),
        .do_writeback_o (nx_writeback),
        .error_o        (nx_error)
    );

    // Snoop FSM with registered handshake and result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            op_q             <= OpRead;
            addr_q           <= '0;
            snoop_ready_q    <= 1'b1;
            lookup_req_q     <= 1'b0;
            lookup_index_q   <= '0;
            lookup_tag_q     <= '0;
            result_valid_q   <= 1'b0;
            snoop_result_q   <= ResNohit;
            upd_valid_q      <= 1'b0;
            upd_index_q      <= '0;
            upd_way_q        <= '0;
            upd_mesi_q       <= MesiI;
            wb_pending_q     <= 1'b0;
            wb_req_q         <= 1'b0;
            wb_addr_q        <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to zero unless re-armed below.
            result_valid_q   <= 1'b0;
            snoop_result_q   <= ResNohit;
            upd_valid_q      <= 1'b0;
            upd_index_q      <= '0;
            upd_way_q        <= '0;
            upd_mesi_q       <= MesiI;
            protocol_error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (snoop_valid) begin
                        op_q           <= bus_op_e'(snoop_op);
                        addr_q         <= snoop_addr;
                        lookup_index_q <= indexBits'(addr_index(64'(snoop_addr), offsetBits,
                                                                indexBits));
                        lookup_tag_q   <= tagBits'(addr_tag(64'(snoop_addr), offsetBits,
                                                            indexBits));
                        lookup_req_q   <= 1'b1;
                        snoop_ready_q  <= 1'b0;
                        state_q        <= StLookup;
                    end
                end
                StLookup: begin
                    if (lookup_ack) begin
                        lookup_req_q     <= 1'b0;
                        result_valid_q   <= 1'b1;
                        snoop_result_q   <= nx_result;
                        protocol_error_q <= nx_error;
                        wb_pending_q     <= nx_writeback;
                        if (nx_update) begin
                            upd_valid_q <= 1'b1;
                            upd_index_q <= lookup_index_q;
                            upd_way_q   <= lookup_way;
                            upd_mesi_q  <= nx_mesi;
                        end
                        state_q <= StRespond;
                    end
                end
                StRespond: begin
                    wb_pending_q <= 1'b0;
                    if (wb_pending_q) begin
                        wb_req_q  <= 1'b1;
                        wb_addr_q <= AW'(addr_line_base(64'(addr_q), offsetBits));
                        state_q   <= StWriteback;
                    end else begin
                        snoop_ready_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StWriteback: begin
                    if (wb_ack) begin
                        wb_req_q      <= 1'b0;
                        wb_addr_q     <= '0;
                        snoop_ready_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
            endcase
        end
    end

    assign snoop_ready    = snoop_ready_q;
    assign lookup_req     = lookup_req_q;
    assign lookup_index   = lookup_index_q;
    assign lookup_tag     = lookup_tag_q;
    assign result_valid   = result_valid_q;
    assign snoop_result   = snoop_result_q;
    assign upd_valid      = upd_valid_q;
    assign upd_index      = upd_index_q;
    assign upd_way        = upd_way_q;
    assign upd_mesi       = upd_mesi_q;
    assign wb_req         = wb_req_q;
    assign wb_addr        = wb_addr_q;
    assign protocol_error = protocol_error_q;

endmodule
